// File: rtl/video_ctrl_regbank_pkg.sv
// Shared types and helpers for the video controller AXI4-Lite register bank.
package video_ctrl_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest supported data bus; strb_merge works at this width and callers
  // resize to their own DATA_W.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Both channel FSM states in one place so checkers can bind to a single signal.
  typedef struct packed {
    wr_state_t wr_state;
    rd_state_t rd_state;
  } fsm_dbg_t;

  // Replace the byte lanes of old_val selected by wstrb with the lanes of wdata.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_STRB_W-1:0] wstrb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_ctrl_regbank_wr_ctrl.sv
// Write-channel controller: AW/W acceptance in any order, latching of the
// early half, a single-cycle commit strobe, and the B response.
module video_ctrl_regbank_wr_ctrl
  import video_ctrl_regbank_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  commit_o,
  output logic [ADDR_W-1:0]     commit_addr_o,
  output logic [DATA_W-1:0]     commit_data_o,
  output logic [DATA_W/8-1:0]   commit_strb_o,
  input  logic                  commit_err_i,
  output logic [1:0]            state_o
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_t           state_q, state_d;
  logic                ready_en_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs, w_hs;

  // Ready/valid outputs per state, handshake detection and next state.
  always_comb begin
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    commit_o  = 1'b0;
    state_d   = state_q;
    case (state_q)
      W_IDLE: begin
        awready_o = ready_en_q;
        wready_o  = ready_en_q;
      end
      W_ADDR:  wready_o  = 1'b1;
      W_DATA:  awready_o = 1'b1;
      W_RESP:  bvalid_o  = 1'b1;
      default: ;
    endcase
    aw_hs = awvalid_i && awready_o;
    w_hs  = wvalid_i && wready_o;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_o = 1'b1;
          state_d  = W_RESP;
        end else if (aw_hs) begin
          state_d = W_ADDR;
        end else if (w_hs) begin
          state_d = W_DATA;
        end
      end
      W_ADDR: if (w_hs) begin
        commit_o = 1'b1;
        state_d  = W_RESP;
      end
      W_DATA: if (aw_hs) begin
        commit_o = 1'b1;
        state_d  = W_RESP;
      end
      W_RESP: if (bready_i) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Commit operands: the half that arrived early comes from its latch.
  always_comb begin
    commit_addr_o = (state_q == W_ADDR) ? awaddr_q : awaddr_i;
    commit_data_o = (state_q == W_DATA) ? wdata_q : wdata_i;
    commit_strb_o = (state_q == W_DATA) ? wstrb_q : wstrb_i;
    bresp_d       = bresp_q;
    if (commit_o) bresp_d = commit_err_i ? RESP_SLVERR : RESP_OKAY;
  end

  // State, early-half latches and response register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= W_IDLE;
      ready_en_q <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      bresp_q    <= bresp_d;
      if (aw_hs) awaddr_q <= awaddr_i;
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
    end
  end

  assign bresp_o = bresp_q;
  assign state_o = state_q;

endmodule

// File: rtl/video_ctrl_regbank.sv
// AXI4-Lite register bank for the video controller: RW registers with byte
// strobes and write pulses, RO status registers, SLVERR outside the bank.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high; a VALID, once raised, holds its payload stable and only drops
// after that transfer.
module video_ctrl_regbank
  import video_ctrl_regbank_pkg::*;
#(
  parameter int                         NUM_REGS  = 16,
  parameter int                         DATA_W    = 32,
  parameter int                         ADDR_W    = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic                wr_commit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [IDX_W-1:0]    wr_idx;
  logic                wr_in_range;
  logic [1:0]          wr_state_dbg;

  rd_state_t           rd_state_q, rd_state_d;
  logic                rd_ready_en_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d, rd_sel;
  logic [1:0]          rresp_q, rresp_d;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_in_range;
  logic                ar_hs;

  fsm_dbg_t            fsm_dbg;
  logic                unused_bits;

  video_ctrl_regbank_wr_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_ctrl (
    .clk_i         (ACLK),
    .rst_i         (ARESET),
    .awaddr_i      (S_AXI_AWADDR),
    .awvalid_i     (S_AXI_AWVALID),
    .awready_o     (S_AXI_AWREADY),
    .wdata_i       (S_AXI_WDATA),
    .wstrb_i       (S_AXI_WSTRB),
    .wvalid_i      (S_AXI_WVALID),
    .wready_o      (S_AXI_WREADY),
    .bresp_o       (S_AXI_BRESP),
    .bvalid_o      (S_AXI_BVALID),
    .bready_i      (S_AXI_BREADY),
    .commit_o      (wr_commit),
    .commit_addr_o (wr_addr),
    .commit_data_o (wr_data),
    .commit_strb_o (wr_strb),
    .commit_err_i  (!wr_in_range),
    .state_o       (wr_state_dbg)
  );

  // Register index decode; NUM_REGS may equal 2^IDX_W, so compare one bit wider.
  assign wr_idx      = wr_addr[ADDR_W-1:ADDR_LSB];
  assign rd_idx      = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
  assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS));
  assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS));

  // Strobed update and write pulse for the addressed RW register only.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit && !RO_MASK[i] && (wr_idx == IDX_W'(i))) begin
        regs_d[i]     = DATA_W'(strb_merge(MAX_DATA_W'(regs_q[i]),
                                           MAX_DATA_W'(wr_data),
                                           MAX_STRB_W'(wr_strb)));
        wr_pulse_d[i] = 1'b1;
      end
    end
  end

  // Register array and write pulses; reset restores every slot's RESET_VAL.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else begin
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read FSM: select the source at the AR handshake and hold it until R completes.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_sel = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i];
    end
    rd_state_d    = rd_state_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    S_AXI_ARREADY = rd_ready_en_q && (rd_state_q == R_IDLE);
    ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    case (rd_state_q)
      R_IDLE: if (ar_hs) begin
        rd_state_d = R_DATA;
        rdata_d    = rd_in_range ? rd_sel : '0;
        rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read state and response registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q    <= R_IDLE;
      rd_ready_en_q <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
    end else begin
      rd_state_q    <= rd_state_d;
      rd_ready_en_q <= 1'b1;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
    end
  end

  assign S_AXI_RVALID = (rd_state_q == R_DATA);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign wr_pulse     = wr_pulse_q;

  // Expose RW contents to the pipeline; RO slots are driven as zero.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  // Debug view of both FSMs; PROT, sub-word address bits and status slots of
  // RW registers carry no function here.
  assign fsm_dbg     = '{wr_state: wr_state_t'(wr_state_dbg), rd_state: rd_state_q};
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], status_in, fsm_dbg};

endmodule

// File: tb/tb_video_ctrl_regbank.sv
// Self-checking bench for video_ctrl_regbank (16 x 32-bit, register 5 read-only).
module tb_video_ctrl_regbank;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0020;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic [31:0] rst_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  function automatic logic [NR*32-1:0] mk_reset();
    logic [NR*32-1:0] r;
    for (int i = 0; i < NR; i++) r[i*32 +: 32] = rst_word(i);
    return r;
  endfunction

  localparam logic [NR*32-1:0] RSTV = mk_reset();

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        awaddr = '0;
  logic [2:0]        awprot = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [7:0]        araddr = '0;
  logic [2:0]        arprot = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [NR*32-1:0]  reg_q;
  logic [NR*32-1:0]  status_in;
  logic [NR-1:0]     wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [31:0] model [NR];

  video_ctrl_regbank #(
    .NUM_REGS (NR),
    .DATA_W   (32),
    .ADDR_W   (8),
    .RO_MASK  (RO),
    .RESET_VAL(RSTV)
  ) dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_q         (reg_q),
    .status_in     (status_in),
    .wr_pulse      (wr_pulse)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic reset_model();
    for (int i = 0; i < NR; i++) model[i] = rst_word(i);
  endtask

  function automatic logic [31:0] exp_status(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : 32'h5A5A_0000 + 32'(i);
  endfunction

  task automatic check_reg_q(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*32 +: 32], RO[i] ? 32'h0 : model[i]);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", {62'h0, bresp}, {62'h0, exp_b_q.pop_front()});
    end
    if (!rst && rvalid && rready) begin
      if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", {30'h0, rresp, rdata}, {30'h0, exp_r_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  // b_dly < 0 leaves the B response pending.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int idx;
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [NR-1:0] epulse;
    idx = int'(addr) >> 2;
    epulse = '0;
    if (idx >= NR) exp_b_q.push_back(SLVERR);
    else begin
      exp_b_q.push_back(OKAY);
      if (!RO[idx]) epulse[idx] = 1'b1;
    end
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc <= 40) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      if (!(aw_done && w_done)) begin
        check("bvalid_early", bvalid, 0);
        if (aw_done) check("awready_in_w_addr", awready, 0);
        if (w_done)  check("wready_in_w_data", wready, 0);
      end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 0, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      void'(exp_b_q.pop_back());
      return;
    end
    check("bvalid_after_commit", bvalid, 1);
    check("wr_pulse_on_commit", wr_pulse, epulse);
    if (idx < NR && !RO[idx])
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    if (b_dly < 0) return;
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1);
      check("wr_pulse_one_cycle", wr_pulse, 0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
    check("wr_pulse_idle", wr_pulse, 0);
  endtask

  // r_dly < 0 leaves the R response pending.
  task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
    int idx;
    int cyc;
    bit done, hs;
    logic [33:0] e;
    idx = int'(addr) >> 2;
    if (idx >= NR) e = {SLVERR, 32'h0};
    else if (RO[idx]) e = {OKAY, exp_status(idx)};
    else e = {OKAY, model[idx]};
    exp_r_q.push_back(e);
    done = 0; cyc = 0;
    while (!done && cyc <= 40) begin
      if (cyc >= ar_dly) begin arvalid = 1'b1; araddr = addr; end
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin done = 1; arvalid = 1'b0; end
      else check("rvalid_early", rvalid, 0);
      cyc++;
    end
    if (!done) begin
      check("read_handshake_timeout", 0, 1);
      arvalid = 1'b0;
      void'(exp_r_q.pop_back());
      return;
    end
    check("rvalid_after_ar", rvalid, 1);
    check("arready_in_r_data", arready, 0);
    if (r_dly < 0) return;
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", {30'h0, rresp, rdata}, {30'h0, e});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", rvalid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " awready"}, awready, 0);
    check({tag, " wready"}, wready, 0);
    check({tag, " arready"}, arready, 0);
    check({tag, " bvalid"}, bvalid, 0);
    check({tag, " rvalid"}, rvalid, 0);
    check({tag, " wr_pulse"}, wr_pulse, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " bresp"}, bresp, 0);
    check({tag, " rresp"}, rresp, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NR; i++) status_in[i*32 +: 32] = exp_status(i);
    rst = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_reg_q("reset");

    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("ready_held_until_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("ready_after_reset", {awready, wready, arready}, 3'b111);

    // Fill every register, then read back.
    for (int i = 0; i < NR; i++) axi_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    check_reg_q("fill");
    for (int i = 0; i < NR; i++) axi_read(8'(i * 4), 0, 0);

    // Byte-strobe merge on register 2.
    axi_write(8'h08, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    axi_write(8'h08, 32'h1122_3344, 4'b0101, 0, 0, 1);
    check("strb_merge_reg_q", reg_q[2*32 +: 32], 32'hAA22_CC44);
    axi_read(8'h08, 0, 0);

    // Skewed AW/W, both orders.
    axi_write(8'h0C, 32'h1357_9BDF, 4'hF, 3, 0, 0);
    axi_read(8'h0C, 0, 0);
    axi_write(8'h10, 32'h2468_ACE0, 4'hF, 0, 3, 2);
    axi_read(8'h10, 1, 0);

    // Write to the read-only register.
    axi_write(8'h14, 32'h0, 4'hF, 0, 0, 0);
    axi_read(8'h14, 0, 0);

    // Out of range write and read; sub-word address bits are ignored.
    axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(8'h40, 0, 0);
    axi_read(8'h43, 0, 1);
    axi_read(8'h1B, 0, 0);
    check_reg_q("after_oor");

    // Read and write to the same register on the same edge: old value returned.
    fork
      axi_write(8'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      axi_read(8'h20, 0, 0);
    join
    axi_read(8'h20, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    check_reg_q("random");

    // Responses held pending, then an asynchronous reset mid-response.
    axi_write(8'h04, 32'h0BAD_0BAD, 4'hF, 0, 0, -1);
    axi_read(8'h04, 0, -1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("pending_bvalid", bvalid, 1);
      check("pending_rvalid", rvalid, 1);
      check("pending_rdata", rdata, 32'h0BAD_0BAD);
    end
    #2 rst = 1'b1;
    #1;
    exp_b_q.delete();
    exp_r_q.delete();
    reset_model();
    check_reset_outputs("async_reset");
    check_reg_q("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset2", {awready, wready, arready}, 3'b111);
    axi_read(8'h04, 0, 0);
    axi_write(8'h04, 32'h7777_8888, 4'b1100, 0, 0, 0);
    axi_read(8'h04, 0, 0);

    repeat (3) @(posedge clk);
    check("b_queue_empty", exp_b_q.size(), 0);
    check("r_queue_empty", exp_r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
